// File: rtl/uart_tx_ctrl.sv
// UART transmit control FSM: sequences load, per-bit shift and done
// strobes for a start + data + parity + stop frame.
module uart_tx_ctrl #(
  parameter int WORD_LENGTH = 8,
  parameter int BAUD_DIV    = 5208
) (
  input  logic clk,
  input  logic reset,
  input  logic transmit,
  output logic load,
  output logic shift,
  output logic transmit_int,
  output logic busy,
  output logic tx_done
);

  localparam int FRAME = WORD_LENGTH + 3;
  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int CW = $clog2(FRAME);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(FRAME - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            transmit_d;
  logic [BW-1:0]   baud_cnt;
  logic [CW-1:0]   bit_cnt;
  logic            start;
  logic            baud_end;

  assign start    = transmit & ~transmit_d;
  assign baud_end = (baud_cnt == BAUD_LAST);

  // Resetting high keeps a request held through reset from firing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) transmit_d <= 1'b1;
    else        transmit_d <= transmit;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else if (state == IDLE && start) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else if (state == SEND) begin
      if (baud_end) begin
        baud_cnt <= '0;
        bit_cnt  <= bit_cnt + 1'b1;
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    load         = 1'b0;
    shift        = 1'b0;
    transmit_int = 1'b0;
    tx_done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        load      = 1'b1;
        state_nxt = SEND;
      end
      SEND: begin
        transmit_int = 1'b1;
        if (baud_end) begin
          shift = 1'b1;
          if (bit_cnt == BIT_LAST) state_nxt = DONE;
        end
      end
      DONE: begin
        tx_done   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: directed scenarios plus random requests,
// checked cycle by cycle against a frame-timeline model.
module tb_uart_tx_ctrl;

  localparam int WL = 8;
  localparam int BD = 4;
  localparam int FB = (WL + 3) * BD;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic transmit = 1'b0;
  logic load;
  logic shift;
  logic transmit_int;
  logic busy;
  logic tx_done;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int load_cyc = 0;
  int shifts = 0;
  int dones = 0;
  bit active = 1'b0;
  bit prev = 1'b1;
  bit last_busy = 1'b0;

  uart_tx_ctrl #(
    .WORD_LENGTH(WL),
    .BAUD_DIV(BD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .transmit(transmit),
    .load(load),
    .shift(shift),
    .transmit_int(transmit_int),
    .busy(busy),
    .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  function automatic int rel();
    return cyc - load_cyc;
  endfunction

  // Frame timeline: load at offset 0, FB send cycles, then done.
  function automatic logic [4:0] expect_out();
    int r;
    logic sd;
    if (!reset || !active) return 5'b0;
    r = rel();
    if (r < 0 || r > FB + 1) return 5'b0;
    sd = (r >= 1) && (r <= FB);
    return {r == 0, sd && (r % BD == 0), sd, 1'b1, r == FB + 1};
  endfunction

  task automatic check(input string tag);
    logic [4:0] obs;
    logic [4:0] exp;
    obs = {load, shift, transmit_int, busy, tx_done};
    exp = expect_out();
    total++;
    if (obs[3]) shifts++;
    if (obs[0]) dones++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b",
             tag, cyc, obs, exp);
    end
  endtask

  task automatic check_cnt(input string tag, input int obs,
                           input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input string tag);
    logic [4:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (!reset) begin
      prev = 1'b1;
      active = 1'b0;
    end else begin
      if (transmit && !prev && !last_busy) begin
        active = 1'b1;
        load_cyc = cyc;
      end
      prev = transmit;
    end
    e = expect_out();
    last_busy = e[1];
    check(tag);
  endtask

  task automatic assert_reset(input string tag);
    reset = 1'b0;
    #1;
    active = 1'b0;
    prev = 1'b1;
    last_busy = 1'b0;
    check(tag);
  endtask

  task automatic run_to(input int r, input string tag);
    for (int i = 0; i < 300 && !(active && rel() == r); i++)
      tick(tag);
    total++;
    assert (active && rel() == r) else begin
      bad++;
      $error("FAIL %s_timeout observed=%0d expected=%0d",
             tag, rel(), r);
    end
  endtask

  task automatic pulse(input string tag);
    transmit = 1'b1;
    tick(tag);
    transmit = 1'b0;
  endtask

  initial begin
    #1;
    assert_reset("reset_async");
    repeat (3) tick("reset_hold");
    reset = 1'b1;
    repeat (5) tick("post_reset_idle");

    shifts = 0; dones = 0;
    pulse("single");
    repeat (FB + 4) tick("single");
    check_cnt("single_shifts", shifts, WL + 3);
    check_cnt("single_done", dones, 1);

    shifts = 0; dones = 0;
    transmit = 1'b1;
    repeat (100) tick("held");
    check_cnt("held_shifts", shifts, WL + 3);
    check_cnt("held_done", dones, 1);
    transmit = 1'b0;
    tick("held_low");
    shifts = 0; dones = 0;
    pulse("held_retrig");
    repeat (FB + 4) tick("held_retrig");
    check_cnt("retrig_shifts", shifts, WL + 3);

    shifts = 0; dones = 0;
    pulse("busy_req");
    run_to(21, "busy_req");
    pulse("busy_req2");
    repeat (FB + 4) tick("busy_req");
    check_cnt("busy_shifts", shifts, WL + 3);
    check_cnt("busy_done", dones, 1);

    pulse("done_edge");
    run_to(FB + 1, "done_edge");
    transmit = 1'b1;
    shifts = 0; dones = 0;
    repeat (12) tick("done_edge_hold");
    check_cnt("done_edge_ignored", shifts, 0);
    transmit = 1'b0;
    tick("done_edge_low");

    shifts = 0; dones = 0;
    pulse("b2b_first");
    run_to(FB + 1, "b2b_first");
    tick("b2b_idle");
    pulse("b2b_second");
    check_cnt("b2b_load", int'(load), 1);
    repeat (FB + 4) tick("b2b_second");
    check_cnt("b2b_shifts", shifts, 2 * (WL + 3));
    check_cnt("b2b_done", dones, 2);

    shifts = 0; dones = 0;
    pulse("rst_mid");
    run_to(5 * BD + 1, "rst_mid");
    assert_reset("rst_mid_abort");
    repeat (3) tick("rst_mid_hold");
    reset = 1'b1;
    repeat (3) tick("rst_mid_rel");
    check_cnt("rst_mid_nodone", dones, 0);
    shifts = 0;
    pulse("rst_mid_new");
    repeat (FB + 4) tick("rst_mid_new");
    check_cnt("rst_mid_shifts", shifts, WL + 3);
    check_cnt("rst_mid_done", dones, 1);

    transmit = 1'b1;
    tick("rst_held_pre");
    assert_reset("rst_held");
    repeat (2) tick("rst_held_hold");
    reset = 1'b1;
    shifts = 0; dones = 0;
    repeat (20) tick("rst_held_rel");
    check_cnt("rst_held_noframe", shifts + dones, 0);
    transmit = 1'b0;
    tick("rst_held_low");
    pulse("rst_held_new");
    repeat (FB + 4) tick("rst_held_new");
    check_cnt("rst_held_shifts", shifts, WL + 3);

    repeat (600) begin
      if ($urandom_range(0, 7) == 0) transmit = ~transmit;
      tick("random");
    end
    transmit = 1'b0;
    repeat (FB + 4) tick("random_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameter WORD_LENGTH, default 8: data bits per frame; frame = 1 start + WORD_LENGTH data + 1 parity + 1 stop = WORD_LENGTH+3 bits.
REQ-002 Parameter BAUD_DIV, default 5208: clk cycles per bit period; legal range >= 2.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 transmit  input  1  frame request; a rising edge starts a frame.
REQ-006 load  output  1  one-cycle strobe; shift register captures {stop, parity, data, start}.
REQ-007 shift  output  1  one-cycle strobe; shift register advances one bit.
REQ-008 transmit_int  output  1  high while the frame is on the line; low forces the serial line to idle-high.
REQ-009 busy  output  1  high whenever the FSM is not in IDLE.
REQ-010 tx_done  output  1  one-cycle pulse at frame completion.

Function
REQ-011 Four states SHALL be used: IDLE, LOAD, SEND, DONE.
REQ-012 transmit SHALL be registered into transmit_d each cycle.
REQ-013 start SHALL be defined as transmit & ~transmit_d, evaluated only in IDLE.
REQ-014 IDLE: if start, next state SHALL be LOAD; otherwise remain in IDLE.
REQ-015 LOAD SHALL last exactly one cycle, with load=1, and then go unconditionally to SEND.
REQ-016 On SEND entry, baud_cnt and bit_cnt SHALL be 0.
REQ-017 In SEND, transmit_int SHALL be 1 every cycle.
REQ-018 In SEND, baud_cnt SHALL count 0..BAUD_DIV-1 and wrap to 0.
REQ-019 baud_cnt width SHALL be clog2(BAUD_DIV).
REQ-020 bit_cnt SHALL be 4 bits for the default WORD_LENGTH, and clog2(WORD_LENGTH+3) bits in general.
REQ-021 When baud_cnt==BAUD_DIV-1 in SEND, shift SHALL be 1 for that cycle, and bit_cnt SHALL increment.
REQ-022 When baud_cnt==BAUD_DIV-1 and bit_cnt==WORD_LENGTH+2 in SEND, next state SHALL be DONE; shift is still asserted on that cycle.
REQ-023 Each bit SHALL be driven for exactly BAUD_DIV cycles; SEND SHALL last exactly (WORD_LENGTH+3)*BAUD_DIV cycles.
REQ-024 DONE SHALL last exactly one cycle, with tx_done=1 and transmit_int=0, and then go to IDLE.
REQ-025 load, shift, transmit_int and tx_done SHALL be 0 in every state other than the one stated above.
REQ-026 busy SHALL be 1 in LOAD, SEND and DONE, and 0 in IDLE.
REQ-027 Latency: a transmit rising edge sampled at edge N gives load=1 in cycle N+1, and the start bit on the line from cycle N+2.
REQ-028 Rising edges of transmit while busy=1 SHALL be ignored; there is no queuing.
REQ-029 A transmit held high across DONE SHALL NOT start a new frame; a new frame requires a fresh low-to-high transition seen in IDLE.
REQ-030 A rising edge arriving in the DONE cycle SHALL be ignored; an edge in the first IDLE cycle SHALL be accepted.
REQ-031 load and shift SHALL never be asserted in the same cycle.
REQ-032 Counters SHALL hold their value outside SEND and SHALL be cleared on entering LOAD.

Reset
REQ-033 While reset=0, the following SHALL apply asynchronously: state=IDLE; baud_cnt=0; bit_cnt=0; transmit_d=1; load=0; shift=0; transmit_int=0; busy=0; tx_done=0.
REQ-034 transmit_d resetting to 1 SHALL prevent a spurious frame when transmit is held high through reset release.
REQ-035 Reset asserted mid-frame SHALL abort the frame immediately, line idle-high, with no tx_done pulse.
REQ-036 After reset release, the block SHALL accept a new rising edge of transmit normally.

Verification
REQ-037 Single frame, BAUD_DIV=4, transmit pulsed at edge 10 -> load=1 in cycle 11; transmit_int=1 in cycles 12..55; shift pulses in cycles 15,19,...,55 (11 pulses); tx_done=1 in cycle 56; busy=0 from cycle 57.
REQ-038 Held request: transmit high for 100 cycles, BAUD_DIV=4 -> exactly one frame, one tx_done pulse; no restart after DONE until transmit goes low then high.
REQ-039 Request during busy: second rising edge at SEND cycle 20 -> ignored; still exactly 11 shift pulses and one tx_done.
REQ-040 Back-to-back: rising edge in the first IDLE cycle after DONE -> load=1 in the next cycle; second frame timing identical to the first.
REQ-041 Reset mid-frame: reset=0 after the 5th shift pulse -> all outputs 0 within the same cycle; no tx_done; after release, a new request yields a full 11-bit frame.
REQ-042 Reset release with transmit=1 held -> no frame starts; busy stays 0 until transmit toggles low then high.
